noc_packet_parser: RTL and testbench
====================================

NOC_PACKET_PARSER -- requirements
Module: noc_packet_parser

Interface
REQ-001 SHALL have parameter TILE_ID, default 8'h00, local tile address compared against header dest field.
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have ports: clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have ports: clk_in_rst_high  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have inputs stream_in_TVALID 1, stream_in_TDATA 32, stream_in_TKEEP 4, stream_in_TLAST 1, and output stream_in_TREADY 1: packet stream from the NoC input buffer.
REQ-006 SHALL have outputs stream_out_TVALID 1, stream_out_TDATA 32, stream_out_TKEEP 4, stream_out_TLAST 1, and input stream_out_TREADY 1: header-stripped payload to the tile message queue.
REQ-007 SHALL have outputs msg_src 8, msg_qid 8, msg_len 8: sideband of the packet currently on stream_out, stable from the first to the last payload beat.
REQ-008 SHALL have outputs err_short 1 and err_long 1 (single-cycle pulses), plus pkt_ok_cnt CNT_W and pkt_drop_cnt CNT_W.

Function
REQ-009 SHALL treat the first beat of every packet as a header: [7:0] dest, [15:8] src, [23:16] qid, [31:24] len (payload words, 0-255).
REQ-010 SHALL implement states HDR, PAYLOAD, DROP; reset state HDR.
REQ-011 SHALL drive stream_in_TREADY in HDR as ~out_valid, where out_valid is the output register's valid bit, so sideband never changes under a pending beat.
REQ-012 SHALL drive stream_in_TREADY in PAYLOAD as ~out_valid | stream_out_TREADY, and in DROP as 1.
REQ-013 On a header handshake with dest==TILE_ID, len>0 and TLAST=0, SHALL latch src/qid/len into msg_*, clear word counter, and go to PAYLOAD.
REQ-014 On a header handshake with dest!=TILE_ID, SHALL increment pkt_drop_cnt, stay in HDR if TLAST=1, else go to DROP; no output beats are produced.
REQ-015 On a header handshake with dest match and len==0, SHALL produce no output beats and increment pkt_ok_cnt if TLAST=1; if TLAST=0, SHALL pulse err_long and go to DROP.
REQ-016 On a header handshake with dest match, len>0 and TLAST=1, SHALL pulse err_short, increment pkt_drop_cnt, and stay in HDR.
REQ-017 In PAYLOAD, each accepted beat SHALL load the output register (TDATA, TKEEP unchanged) with stream_out_TVALID=1 on the next cycle: latency 1 cycle, throughput 1 beat/cycle.
REQ-018 The output register SHALL hold its value while stream_out_TVALID & ~stream_out_TREADY; TVALID SHALL never drop without a handshake.
REQ-019 In PAYLOAD, if input TLAST arrives at word count < len, SHALL output the beat with TLAST=1, pulse err_short, increment pkt_drop_cnt, and return to HDR.
REQ-020 In PAYLOAD, if word count reaches len with input TLAST=1, SHALL output TLAST=1, increment pkt_ok_cnt, and return to HDR.
REQ-021 In PAYLOAD, if word count reaches len with input TLAST=0, SHALL force output TLAST=1, pulse err_long, increment pkt_drop_cnt, and go to DROP.
REQ-022 In DROP, SHALL accept and discard beats and return to HDR on the TLAST beat.
REQ-023 Word counter SHALL be 8 bits wide and compared against len; it cannot wrap because len<=255 forces exit.
REQ-024 Statistics counters SHALL wrap modulo 2^CNT_W; at most one counter increments per cycle.
REQ-025 Error pulses SHALL be asserted in the cycle following the triggering input handshake, aligned with the output register load.

Reset
REQ-026 While clk_in_rst_high=1, SHALL force state HDR, stream_out_TVALID=0, stream_out_TDATA/TKEEP/TLAST=0, msg_*=0, err_*=0, counters=0, and stream_in_TREADY=0.
REQ-027 Reset asserted mid-packet SHALL discard the in-flight packet; after deassertion the next beat is treated as a header.

Verification
REQ-028 Header 0x03_05_07_00, then 3 beats 0xA,0xB,0xC (last on 0xC), TREADY=1 -> 3 output beats, 1-cycle latency, TLAST on 0xC, msg_src=7, msg_qid=5, msg_len=3, pkt_ok_cnt=1.
REQ-029 Header dest=0x01 with TILE_ID=0 plus 4 payload beats -> no output TVALID, TREADY held high, pkt_drop_cnt=1, next header parsed normally.
REQ-030 len=4, TLAST on 2nd payload beat -> 2 output beats, TLAST on 2nd, err_short pulse, pkt_drop_cnt=1.
REQ-031 len=2, 5 payload beats -> 2 output beats, forced TLAST on 2nd, err_long pulse, 3 beats dropped, back in HDR.
REQ-032 len=8, stream_out_TREADY toggled randomly -> data order preserved, no beat lost or duplicated, TVALID/TDATA stable while stalled, next header not accepted before final output handshake.
REQ-033 Assert reset after 2 of 4 payload beats -> TVALID=0 immediately, counters=0; following packet parsed from header.

Source files
------------

// File: rtl/noc_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : noc_packet_parser
// Purpose  : Parses NoC packets: checks the header against the local tile,
//            strips it, forwards the payload through a one-deep output
//            register with msg_* sideband, and flags short/long packets.
// Revision : 1.0 - initial release
// ============================================================================
module noc_packet_parser #(
  parameter logic [7:0] TILE_ID = 8'h00,
  parameter int         CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             clk_in_rst_high,
  // packet stream from the NoC input buffer
  input  logic             stream_in_TVALID,
  input  logic [31:0]      stream_in_TDATA,
  input  logic [3:0]       stream_in_TKEEP,
  input  logic             stream_in_TLAST,
  output logic             stream_in_TREADY,
  // header-stripped payload to the tile message queue
  output logic             stream_out_TVALID,
  output logic [31:0]      stream_out_TDATA,
  output logic [3:0]       stream_out_TKEEP,
  output logic             stream_out_TLAST,
  input  logic             stream_out_TREADY,
  // sideband of the packet currently on stream_out
  output logic [7:0]       msg_src,
  output logic [7:0]       msg_qid,
  output logic [7:0]       msg_len,
  // status
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt
);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       in_fire;
  logic       out_fire;
  logic [7:0] hdr_dest;
  logic [7:0] hdr_len;
  logic [7:0] word_cnt;
  logic [7:0] word_cnt_inc;
  logic [7:0] word_cnt_nxt;
  logic       load_out;
  logic       last_nxt;
  logic       latch_hdr;
  logic       short_nxt;
  logic       long_nxt;
  logic       inc_ok;
  logic       inc_drop;

  assign hdr_dest     = stream_in_TDATA[7:0];
  assign hdr_len      = stream_in_TDATA[31:24];
  assign word_cnt_inc = word_cnt + 8'd1;
  assign in_fire      = stream_in_TVALID & stream_in_TREADY;
  assign out_fire     = stream_out_TVALID & stream_out_TREADY;

  // Input ready: in HDR wait for the output register to drain so msg_* never
  // changes under a beat still waiting on stream_out; held low during reset.
  always_comb begin
    stream_in_TREADY = 1'b0;
    if (!clk_in_rst_high) begin
      case (state)
        HDR:     stream_in_TREADY = ~stream_out_TVALID;
        PAYLOAD: stream_in_TREADY = ~stream_out_TVALID | stream_out_TREADY;
        DROP:    stream_in_TREADY = 1'b1;
        default: stream_in_TREADY = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
    if (clk_in_rst_high) state <= HDR;
    else                 state <= state_nxt;
  end

  // Next-state decode plus the per-handshake actions that get registered.
  always_comb begin
    state_nxt    = state;
    load_out     = 1'b0;
    last_nxt     = 1'b0;
    latch_hdr    = 1'b0;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;
    inc_ok       = 1'b0;
    inc_drop     = 1'b0;
    word_cnt_nxt = word_cnt;
    case (state)
      HDR: begin
        if (in_fire) begin
          if (hdr_dest != TILE_ID) begin
            inc_drop = 1'b1;
            if (!stream_in_TLAST) state_nxt = DROP;
          end else if (hdr_len == 8'd0) begin
            // empty message: valid only if nothing follows the header
            if (stream_in_TLAST) begin
              inc_ok = 1'b1;
            end else begin
              long_nxt  = 1'b1;
              state_nxt = DROP;
            end
          end else if (stream_in_TLAST) begin
            short_nxt = 1'b1;
            inc_drop  = 1'b1;
          end else begin
            latch_hdr    = 1'b1;
            word_cnt_nxt = 8'd0;
            state_nxt    = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_fire) begin
          load_out     = 1'b1;
          word_cnt_nxt = word_cnt_inc;
          if (word_cnt_inc == msg_len) begin
            // declared length reached: always terminate the output packet
            last_nxt = 1'b1;
            if (stream_in_TLAST) begin
              inc_ok    = 1'b1;
              state_nxt = HDR;
            end else begin
              long_nxt  = 1'b1;
              inc_drop  = 1'b1;
              state_nxt = DROP;
            end
          end else if (stream_in_TLAST) begin
            last_nxt  = 1'b1;
            short_nxt = 1'b1;
            inc_drop  = 1'b1;
            state_nxt = HDR;
          end
        end
      end
      DROP: begin
        if (in_fire && stream_in_TLAST) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // Output register: loads on an accepted payload beat, otherwise holds until
  // the downstream handshake.
  always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
    if (clk_in_rst_high) begin
      stream_out_TVALID <= 1'b0;
      stream_out_TDATA  <= 32'd0;
      stream_out_TKEEP  <= 4'd0;
      stream_out_TLAST  <= 1'b0;
    end else if (load_out) begin
      stream_out_TVALID <= 1'b1;
      stream_out_TDATA  <= stream_in_TDATA;
      stream_out_TKEEP  <= stream_in_TKEEP;
      stream_out_TLAST  <= last_nxt;
    end else if (out_fire) begin
      stream_out_TVALID <= 1'b0;
    end
  end

  // Sideband and word counter; msg_* change only on an accepted header.
  always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
    if (clk_in_rst_high) begin
      msg_src  <= 8'd0;
      msg_qid  <= 8'd0;
      msg_len  <= 8'd0;
      word_cnt <= 8'd0;
    end else begin
      word_cnt <= word_cnt_nxt;
      if (latch_hdr) begin
        msg_src <= stream_in_TDATA[15:8];
        msg_qid <= stream_in_TDATA[23:16];
        msg_len <= hdr_len;
      end
    end
  end

  // Error pulses and statistics, aligned with the output register load.
  always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
    if (clk_in_rst_high) begin
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      err_short <= short_nxt;
      err_long  <= long_nxt;
      if (inc_ok)   pkt_ok_cnt   <= pkt_ok_cnt + CNT_W'(1);
      if (inc_drop) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_packet_parser
// Purpose  : Directed self-checking bench for noc_packet_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_packet_parser;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_ready;
  logic [7:0]  msg_src;
  logic [7:0]  msg_qid;
  logic [7:0]  msg_len;
  logic        err_short;
  logic        err_long;
  logic [15:0] ok_cnt;
  logic [15:0] drop_cnt;

  noc_packet_parser #(.TILE_ID(8'h00), .CNT_W(16)) dut (
    .clk_in            (clk_in),
    .clk_in_rst_high   (rst),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_ready),
    .msg_src           (msg_src),
    .msg_qid           (msg_qid),
    .msg_len           (msg_len),
    .err_short         (err_short),
    .err_long          (err_long),
    .pkt_ok_cnt        (ok_cnt),
    .pkt_drop_cnt      (drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  int          n_short = 0;
  int          n_long = 0;
  int          n_vsamp = 0;
  int          wait_total = 0;
  logic        hs_outv;
  logic        rand_en;
  logic        prev_stall;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Downstream ready: all-ones unless the random stall phase is enabled.
  always @(negedge clk_in) out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;

  // Output monitor: records beats that handshake on the coming edge, counts
  // error pulses and checks that a stalled beat is held.
  always @(negedge clk_in) begin
    #1;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (out_valid) n_vsamp++;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_keep.push_back(out_keep);
        q_last.push_back(out_last);
      end
      if (err_short) n_short++;
      if (err_long) n_long++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One input beat; returns just after the accepting clock edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    @(negedge clk_in);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk_in); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    wait_total += n;
    hs_outv = out_valid;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(negedge clk_in);
    #2;
  endtask

  initial begin
    int base;
    int w0;
    int v0;
    int s0;
    int l0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    rand_en = 1'b0; hs_outv = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    check("rst_msg_src", 32'(msg_src), 32'd0);
    @(negedge clk_in); rst = 1'b0;

    // Basic 3-word packet, 1-cycle latency
    base = q_data.size();
    send(32'h0305_0700, 4'hF, 1'b0);
    send(32'h0000_000A, 4'hF, 1'b0);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'h0000_000A);
    send(32'h0000_000B, 4'hF, 1'b0);
    send(32'h0000_000C, 4'h3, 1'b1);
    drain(4);
    check("p1_count", 32'(q_data.size() - base), 32'd3);
    if (q_data.size() - base == 3) begin
      check("p1_d0", q_data[base], 32'hA);
      check("p1_d1", q_data[base+1], 32'hB);
      check("p1_d2", q_data[base+2], 32'hC);
      check("p1_last", {29'd0, q_last[base], q_last[base+1], q_last[base+2]}, 32'b001);
      check("p1_keep", 32'(q_keep[base+2]), 32'h3);
    end
    check("p1_src", 32'(msg_src), 32'd7);
    check("p1_qid", 32'(msg_qid), 32'd5);
    check("p1_len", 32'(msg_len), 32'd3);
    check("p1_ok", 32'(ok_cnt), 32'd1);

    // Foreign destination: swallowed, never stalls
    base = q_data.size(); w0 = wait_total; v0 = n_vsamp;
    send(32'h0400_0001, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h100 + i, 4'hF, i == 3);
    drain(3);
    check("p2_no_out", 32'(q_data.size() - base), 32'd0);
    check("p2_no_valid", 32'(n_vsamp - v0), 32'd0);
    check("p2_no_stall", 32'(wait_total - w0), 32'd0);
    check("p2_drop", 32'(drop_cnt), 32'd1);
    base = q_data.size();
    send(32'h0100_0900, 4'hF, 1'b0);
    send(32'h0000_0055, 4'hF, 1'b1);
    drain(3);
    check("p2b_count", 32'(q_data.size() - base), 32'd1);
    if (q_data.size() - base == 1) begin
      check("p2b_data", q_data[base], 32'h55);
      check("p2b_last", 32'(q_last[base]), 32'd1);
    end
    check("p2b_src", 32'(msg_src), 32'd9);
    check("p2b_ok", 32'(ok_cnt), 32'd2);

    // Short packet: len 4, TLAST on 2nd payload beat
    base = q_data.size(); s0 = n_short;
    send(32'h0400_0200, 4'hF, 1'b0);
    send(32'h0000_0010, 4'hF, 1'b0);
    send(32'h0000_0011, 4'hF, 1'b1);
    drain(3);
    check("p3_count", 32'(q_data.size() - base), 32'd2);
    if (q_data.size() - base == 2)
      check("p3_last", {30'd0, q_last[base], q_last[base+1]}, 32'b01);
    check("p3_err_short", 32'(n_short - s0), 32'd1);
    check("p3_drop", 32'(drop_cnt), 32'd2);
    check("p3_ok", 32'(ok_cnt), 32'd2);

    // Long packet: len 2, 5 payload beats
    base = q_data.size(); l0 = n_long; w0 = wait_total;
    send(32'h0200_0300, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) send(32'h20 + i, 4'hF, i == 4);
    drain(3);
    check("p4_count", 32'(q_data.size() - base), 32'd2);
    if (q_data.size() - base == 2) begin
      check("p4_last", {30'd0, q_last[base], q_last[base+1]}, 32'b01);
      check("p4_d1", q_data[base+1], 32'h21);
    end
    check("p4_err_long", 32'(n_long - l0), 32'd1);
    check("p4_drop", 32'(drop_cnt), 32'd3);

    // Random downstream stalls on an 8-word packet
    base = q_data.size();
    rand_en = 1'b1;
    send(32'h0801_0400, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) send(32'h30 + i, 4'hF, i == 7);
    send(32'h0100_0B00, 4'hF, 1'b0);
    check("p5_hdr_after_drain", 32'(hs_outv), 32'd0);
    check("p5_count_at_hdr", 32'(q_data.size() - base), 32'd8);
    send(32'h0000_0099, 4'hF, 1'b1);
    rand_en = 1'b0;
    drain(6);
    check("p5_count", 32'(q_data.size() - base), 32'd9);
    if (q_data.size() - base == 9) begin
      for (int i = 0; i < 8; i++) begin
        check("p5_data", q_data[base+i], 32'h30 + i);
        check("p5_last", 32'(q_last[base+i]), 32'(i == 7));
      end
      check("p5b_data", q_data[base+8], 32'h99);
    end
    check("p5_ok", 32'(ok_cnt), 32'd4);
    check("p5_src", 32'(msg_src), 32'h0B);

    // Reset in the middle of a packet
    send(32'h0400_0600, 4'hF, 1'b0);
    send(32'h0000_0040, 4'hF, 1'b0);
    send(32'h0000_0041, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_ok", 32'(ok_cnt), 32'd0);
    check("r_drop", 32'(drop_cnt), 32'd0);
    check("r_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    base = q_data.size();
    send(32'h0100_0C00, 4'hF, 1'b0);
    send(32'h0000_0077, 4'hF, 1'b1);
    drain(3);
    check("r_count", 32'(q_data.size() - base), 32'd1);
    if (q_data.size() - base == 1) check("r_data", q_data[base], 32'h77);
    check("r_src", 32'(msg_src), 32'h0C);
    check("r_ok_after", 32'(ok_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
